tc_pl_spi_tx_arb: RTL and testbench

Round-robin arbiter that shares the single SPI byte transmitter among NREQ configuration controllers, for example the gain-DAC controller and other PL setters. It grants one requester at a time and routes stx_idle, stx_dreq, stx_valid and stx_data between that requester and the transmitter. It drives a one-hot chip-select routing vector and holds it until the transmitter drains. It enforces an inter-frame gap and a hold timeout, so a stuck requester cannot lock the SPI bus.

---
 rtl/tc_pl_spi_arb_pkg.sv | 25 ++
 rtl/tc_pl_rr_pick.sv | 36 +++
 rtl/tc_pl_spi_tx_arb.sv | 161 ++++++++++++++++
 tb/tb_tc_pl_spi_tx_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pl_spi_arb_pkg.sv
// Shared types and constants for the PL SPI transmitter arbiter.
// State encoding, default timing constants and a ceil-log2 helper.
package tc_pl_spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam int unsigned GAP_CYC_DEF = 4;
    localparam int unsigned TMO_CYC_DEF = 4096;

    // Ceil-log2 usable in constant expressions (port and parameter widths).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tc_pl_rr_pick.sv
// Round-robin picker: first set request searching upward from last+1 with wrap.
// Purely combinational; returns one-hot pick, its index and an any-request flag.
module tc_pl_rr_pick
    import tc_pl_spi_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        logic          found;
        logic [IW-1:0] j;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        // k=NREQ wraps back onto last itself, so it has the lowest priority
        for (int unsigned k = 1; k <= NREQ; k++) begin
            j = IW'((32'(last) + k) % NREQ);
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/tc_pl_spi_tx_arb.sv
// Round-robin arbiter sharing one SPI byte transmitter among NREQ setters.
// Routes the handshake to the granted requester, holds chip-select until drain.
module tc_pl_spi_tx_arb
    import tc_pl_spi_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned SPI0_0  = 8,
    parameter int unsigned GAP_CYC = GAP_CYC_DEF,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          rq_req,
    output logic [NREQ-1:0]          rq_gnt,
    output logic [NREQ-1:0]          rq_idle,
    output logic [NREQ-1:0]          rq_dreq,
    input  logic [NREQ-1:0]          rq_valid,
    input  logic [NREQ*SPI0_0-1:0]   rq_data,
    input  logic                     stx_idle,
    input  logic                     stx_dreq,
    output logic                     stx_valid,
    output logic [SPI0_0-1:0]        stx_data,
    output logic [NREQ-1:0]          spi_sel,
    output logic                     arb_busy,
    output logic                     tmo_err,
    output logic [clog2(NREQ)-1:0]   tmo_id
);

    localparam int unsigned IW = clog2(NREQ);
    localparam int unsigned TW = clog2(TMO_CYC);
    localparam int unsigned GW = clog2(GAP_CYC + 1);

    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] TMO_SAT  = '1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    arb_state_e state, state_nx;

    logic [IW-1:0]   last, last_nx;
    logic [TW-1:0]   tcnt, tcnt_nx;
    logic [GW-1:0]   gcnt, gcnt_nx;
    logic [NREQ-1:0] gnt_nx, sel_nx;
    logic            tmo_err_nx;
    logic [IW-1:0]   tmo_id_nx;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            req_g;
    logic            tmo_hit;
    logic            hold;

    logic [SPI0_0-1:0] data_a [NREQ];

    tc_pl_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (rq_req),
        .last (last),
        .pick (pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // last doubles as the granted index while in HOLD
    assign req_g   = rq_req[last];
    assign tmo_hit = req_g && (tcnt == TMO_LAST);
    assign hold    = (state == HOLD);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rq_gnt  <= '0;
            spi_sel <= '0;
            last    <= IW'(NREQ - 1);
            tcnt    <= '0;
            gcnt    <= '0;
            tmo_err <= 1'b0;
            tmo_id  <= '0;
        end else begin
            state   <= state_nx;
            rq_gnt  <= gnt_nx;
            spi_sel <= sel_nx;
            last    <= last_nx;
            tcnt    <= tcnt_nx;
            gcnt    <= gcnt_nx;
            tmo_err <= tmo_err_nx;
            tmo_id  <= tmo_id_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any && stx_idle)  state_nx = HOLD;
            HOLD:    if (!req_g || tmo_hit)     state_nx = DRAIN;
            DRAIN:   if (stx_idle)              state_nx = GAP;
            GAP:     if (gcnt == GAP_LAST)      state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        gnt_nx     = rq_gnt;
        sel_nx     = spi_sel;
        last_nx    = last;
        tcnt_nx    = tcnt;
        gcnt_nx    = gcnt;
        tmo_err_nx = 1'b0;
        tmo_id_nx  = tmo_id;
        case (state)
            IDLE: begin
                if (pick_any && stx_idle) begin
                    gnt_nx  = pick_oh;
                    sel_nx  = pick_oh;
                    last_nx = pick_idx;
                    tcnt_nx = '0;
                end
            end
            HOLD: begin
                if (!req_g) begin
                    gnt_nx = '0;
                end else if (tmo_hit) begin
                    gnt_nx     = '0;
                    tmo_err_nx = 1'b1;
                    tmo_id_nx  = last;
                end else if (tcnt != TMO_SAT) begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            DRAIN: begin
                if (stx_idle) begin
                    sel_nx  = '0;
                    gcnt_nx = '0;
                end
            end
            GAP: begin
                gcnt_nx = gcnt + GW'(1);
            end
            default: begin
                gnt_nx = '0;
                sel_nx = '0;
            end
        endcase
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_a[i] = rq_data[i*SPI0_0 +: SPI0_0];
    end

    // Combinational routing, gated by registered state so reset silences it
    assign rq_idle   = hold ? (rq_gnt & {NREQ{stx_idle}}) : '0;
    assign rq_dreq   = hold ? (rq_gnt & {NREQ{stx_dreq}}) : '0;
    assign stx_valid = hold & rq_valid[last];
    assign stx_data  = hold ? data_a[last] : '0;
    assign arb_busy  = (state != IDLE);

endmodule

// File: tb/tb_tc_pl_spi_tx_arb.sv
// Directed bench for tc_pl_spi_tx_arb: grant routing, round-robin order,
// timeout release, drain hold, non-granted isolation and async reset.
module tb_tc_pl_spi_tx_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  rq_req;
    logic [3:0]  rq_gnt;
    logic [3:0]  rq_idle;
    logic [3:0]  rq_dreq;
    logic [3:0]  rq_valid;
    logic [31:0] rq_data;
    logic        stx_idle;
    logic        stx_dreq;
    logic        stx_valid;
    logic [7:0]  stx_data;
    logic [3:0]  spi_sel;
    logic        arb_busy;
    logic        tmo_err;
    logic [1:0]  tmo_id;

    int n_tot = 0;
    int n_bad = 0;

    tc_pl_spi_tx_arb #(
        .NREQ    (4),
        .SPI0_0  (8),
        .GAP_CYC (4),
        .TMO_CYC (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rq_req    (rq_req),
        .rq_gnt    (rq_gnt),
        .rq_idle   (rq_idle),
        .rq_dreq   (rq_dreq),
        .rq_valid  (rq_valid),
        .rq_data   (rq_data),
        .stx_idle  (stx_idle),
        .stx_dreq  (stx_dreq),
        .stx_valid (stx_valid),
        .stx_data  (stx_data),
        .spi_sel   (spi_sel),
        .arb_busy  (arb_busy),
        .tmo_err   (tmo_err),
        .tmo_id    (tmo_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (arb_busy && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(arb_busy), 32'd0);
    endtask

    // Wait for a grant, check it is requester exp, hold it, then release
    task automatic serve(input string tag, input int exp, input int hold,
                         input bit rearm, input int exp_gap);
        int         n;
        int         leak;
        logic [3:0] m;
        n    = 0;
        leak = 0;
        m    = 4'(1) << exp;
        while (rq_gnt == 4'd0 && n < 50) begin
            if (stx_valid !== 1'b0) leak++;
            tick();
            n++;
        end
        if (exp_gap >= 0) begin
            chk({tag, "_gap"},   32'(n),    32'(exp_gap));
            chk({tag, "_quiet"}, 32'(leak), 32'd0);
        end
        chk({tag, "_gnt"},  32'(rq_gnt),   32'(m));
        chk({tag, "_data"}, 32'(stx_data), 32'((exp + 1) * 17));
        for (int i = 1; i < hold; i++) tick();
        chk({tag, "_held"}, 32'(rq_gnt), 32'(m));
        rq_req = rq_req & ~m;
        tick();
        chk({tag, "_rel"}, 32'(rq_gnt), 32'd0);
        if (rearm) rq_req = rq_req | m;
    endtask

    initial begin
        int n;
        int bad;

        rst      = 1'b1;
        rq_req   = 4'd0;
        rq_valid = 4'd0;
        rq_data  = 32'd0;
        stx_idle = 1'b1;
        stx_dreq = 1'b0;
        repeat (3) tick();

        chk("rst_gnt",   32'(rq_gnt),    32'd0);
        chk("rst_sel",   32'(spi_sel),   32'd0);
        chk("rst_busy",  32'(arb_busy),  32'd0);
        chk("rst_tmo",   32'(tmo_err),   32'd0);
        chk("rst_valid", 32'(stx_valid), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single request routed through
        rq_req = 4'b0010;
        tick();
        chk("t1_gnt",  32'(rq_gnt),   32'h2);
        chk("t1_sel",  32'(spi_sel),  32'h2);
        chk("t1_busy", 32'(arb_busy), 32'd1);
        stx_dreq = 1'b1;
        rq_valid = 4'b0010;
        rq_data  = 32'h0000_A500;
        #1;
        chk("t1_dreq",  32'(rq_dreq),   32'h2);
        chk("t1_idle",  32'(rq_idle),   32'h2);
        chk("t1_valid", 32'(stx_valid), 32'd1);
        chk("t1_data",  32'(stx_data),  32'hA5);
        stx_dreq = 1'b0;
        #1;
        chk("t1_dreq0", 32'(rq_dreq), 32'h0);
        rq_req   = 4'd0;
        rq_valid = 4'd0;
        tick();
        chk("t1_drain_gnt", 32'(rq_gnt),  32'h0);
        chk("t1_drain_sel", 32'(spi_sel), 32'h2);
        tick();
        chk("t1_gap_sel", 32'(spi_sel), 32'h0);
        wait_idle("t1");

        // 2: all request together after reset, order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rq_valid = 4'b1111;
        rq_data  = 32'h4433_2211;
        rq_req   = 4'b1111;
        serve("t2_a", 0, 10, 1'b1, -1);
        serve("t2_b", 1, 10, 1'b1, 6);
        serve("t2_c", 2, 10, 1'b1, 6);
        serve("t2_d", 3, 10, 1'b1, 6);
        serve("t2_e", 0, 10, 1'b0, 6);
        rq_req = 4'd0;
        wait_idle("t2");

        // 3: requester 2 never drops, forced release after 64 cycles
        rq_req = 4'b0100;
        n = 0;
        while (rq_gnt == 4'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("t3_gnt", 32'(rq_gnt), 32'h4);
        n   = 1;
        bad = 0;
        while (rq_gnt == 4'b0100 && n < 100) begin
            if (tmo_err !== 1'b0) bad++;
            tick();
            n++;
        end
        chk("t3_hold_len", 32'(n - 1),  32'd64);
        chk("t3_early",    32'(bad),    32'd0);
        chk("t3_tmo_err",  32'(tmo_err), 32'd1);
        chk("t3_tmo_id",   32'(tmo_id),  32'd2);
        chk("t3_rel",      32'(rq_gnt),  32'd0);
        rq_req = 4'b1111;
        tick();
        chk("t3_pulse", 32'(tmo_err), 32'd0);
        chk("t3_id_hold", 32'(tmo_id), 32'd2);
        serve("t3_a", 3, 1, 1'b0, 5);
        serve("t3_b", 0, 1, 1'b0, 6);
        serve("t3_c", 1, 1, 1'b0, 6);
        serve("t3_d", 2, 1, 1'b0, 6);
        wait_idle("t3");

        // 4: drop while transmitter still busy, select held through drain
        rq_req = 4'b0001;
        n = 0;
        while (rq_gnt == 4'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_gnt", 32'(rq_gnt), 32'h1);
        stx_idle = 1'b0;
        #1;
        chk("t4_idle0", 32'(rq_idle), 32'h0);
        rq_req = 4'd0;
        tick();
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (spi_sel == 4'b0001 && stx_valid == 1'b0 && rq_gnt == 4'd0) n++;
            tick();
        end
        chk("t4_hold7", 32'(n), 32'd7);
        stx_idle = 1'b1;
        #1;
        chk("t4_sel_rise", 32'(spi_sel), 32'h1);
        tick();
        chk("t4_sel_clr", 32'(spi_sel),  32'h0);
        chk("t4_gap_busy", 32'(arb_busy), 32'd1);
        wait_idle("t4");

        // 5: non-granted requester cannot reach the transmitter
        rq_valid = 4'b1000;
        rq_data  = 32'hFF00_5A00;
        rq_req   = 4'b0010;
        n = 0;
        while (rq_gnt == 4'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_gnt",   32'(rq_gnt),            32'h2);
        chk("t5_valid", 32'(stx_valid),         32'd0);
        chk("t5_noff",  32'(stx_data == 8'hFF), 32'd0);
        stx_dreq = 1'b1;
        rq_valid = 4'b1010;
        #1;
        chk("t5_dreq",   32'(rq_dreq),   32'h2);
        chk("t5_valid1", 32'(stx_valid), 32'd1);
        chk("t5_data",   32'(stx_data),  32'h5A);
        stx_dreq = 1'b0;
        rq_req   = 4'd0;
        rq_valid = 4'd0;
        wait_idle("t5");

        // 6: async reset mid-HOLD, then pointer restarts at requester 0
        rq_valid = 4'b0100;
        rq_req   = 4'b0100;
        n = 0;
        while (rq_gnt == 4'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_gnt", 32'(rq_gnt), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt",   32'(rq_gnt),    32'h0);
        chk("t6_rst_sel",   32'(spi_sel),   32'h0);
        chk("t6_rst_valid", 32'(stx_valid), 32'd0);
        rq_req = 4'b1001;
        tick();
        chk("t6_rst_id", 32'(tmo_id), 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_first", 32'(rq_gnt), 32'h1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
